// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM states for alu_exec; MUL state exists only with ALU_EXEC_MUL_EN.
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef ALU_EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, WIDTH steps after start, low-half product.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] mcand, mplier;
  logic [CW-1:0] cnt;
  logic busy;
  assign done = busy && cnt == CW'(WIDTH);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      product <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      product <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      product <= product + (mplier[0] ? mcand : '0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: handshaked ALU execution unit with registered result and flags.
// Define ALU_EXEC_MUL_EN to enable the iterative multiplier (code 1000).
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             illegal_o
);
  state_t state, next, acc_state;
  logic accept, legal, slt, ovf_add, ovf_sub, ovf, mul_code, ovf_q, ill_q;
  logic [WIDTH-1:0] add_r, sub_r, alu_r, result_q;
  assign ready_o = state == IDLE || (state == DONE && ready_i);
  assign valid_o = state == DONE;
  assign accept = valid_i && ready_o;
  assign result_o = result_q;
  assign zero_o = valid_o && result_q == '0;
  assign overflow_o = ovf_q;
  assign illegal_o = ill_q;
`ifdef ALU_EXEC_MUL_EN
  logic mul_done;
  logic [WIDTH-1:0] product;
  assign mul_code = ALUCtrl_i == OP_MUL;
  assign acc_state = mul_code ? MUL : DONE;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk_i), .rst(rst_i), .start(accept && mul_code),
    .a(src1_i), .b(src2_i), .done(mul_done), .product(product)
  );
`else
  assign mul_code = 1'b0;
  assign acc_state = DONE;
`endif
  always_comb begin
    add_r = src1_i + src2_i;
    sub_r = src1_i - src2_i;
    ovf_add = src1_i[WIDTH-1] == src2_i[WIDTH-1] && add_r[WIDTH-1] != src1_i[WIDTH-1];
    ovf_sub = src1_i[WIDTH-1] != src2_i[WIDTH-1] && sub_r[WIDTH-1] != src1_i[WIDTH-1];
    slt = sub_r[WIDTH-1] ^ ovf_sub;
    ovf = ALUCtrl_i == OP_ADD ? ovf_add : ALUCtrl_i == OP_SUB ? ovf_sub : 1'b0;
    alu_r = ALUCtrl_i == OP_AND ? src1_i & src2_i :
            ALUCtrl_i == OP_OR  ? src1_i | src2_i :
            ALUCtrl_i == OP_ADD ? add_r :
            ALUCtrl_i == OP_SUB ? sub_r :
            ALUCtrl_i == OP_SLT ? {{(WIDTH-1){1'b0}}, slt} :
            ALUCtrl_i == OP_NOR ? ~(src1_i | src2_i) : '0;
    legal = ALUCtrl_i == OP_AND || ALUCtrl_i == OP_OR || ALUCtrl_i == OP_ADD ||
            ALUCtrl_i == OP_SUB || ALUCtrl_i == OP_SLT || ALUCtrl_i == OP_NOR || mul_code;
  end
  always_comb begin
    next = state;
    if (accept) next = acc_state;
    else if (state == DONE && ready_i) next = IDLE;
`ifdef ALU_EXEC_MUL_EN
    if (state == MUL && mul_done) next = DONE;
`endif
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      result_q <= '0;
      ovf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        result_q <= alu_r;
        ovf_q <= ovf;
        ill_q <= ~legal;
      end
`ifdef ALU_EXEC_MUL_EN
      if (state == MUL && mul_done) result_q <= product;
`endif
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec (both ALU_EXEC_MUL_EN builds).
module tb_alu_exec;
  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, ready_i = 1'b1;
  logic [3:0] ctrl = 4'b0;
  logic [31:0] src1 = '0, src2 = '0;
  logic ready_o, valid_o, zero_o, overflow_o, illegal_o;
  logic [31:0] result_o;
  logic [35:0] obs;
  int checks = 0, failures = 0;
  assign obs = {valid_o, zero_o, overflow_o, illegal_o, result_o};
  always #5 clk = ~clk;
  alu_exec #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .ALUCtrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .zero_o(zero_o), .overflow_o(overflow_o), .illegal_o(illegal_o)
  );
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    ctrl = c;
    src1 = a;
    src2 = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask
  task automatic drain();
    ready_i = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready_o, obs} !== {1'b1, 36'h0}) begin failures++; $display("FAIL reset got=%h exp=%h", {ready_o, obs}, {1'b1, 36'h0}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_add();
    issue(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    checks++;
    if (obs !== {4'b1010, 32'h80000000}) begin failures++; $display("FAIL add_ovf got=%h exp=%h", obs, {4'b1010, 32'h80000000}); end
    drain();
    checks++;
    if ({ready_o, valid_o} !== 2'b10) begin failures++; $display("FAIL add_idle got=%b exp=10", {ready_o, valid_o}); end
  endtask
  task automatic test_sub_slt();
    issue(4'b0110, 32'd5, 32'd5);
    checks++;
    if (obs !== {4'b1100, 32'h0}) begin failures++; $display("FAIL sub_zero got=%h exp=%h", obs, {4'b1100, 32'h0}); end
    drain();
    issue(4'b0110, 32'h80000000, 32'h1);
    checks++;
    if (obs !== {4'b1010, 32'h7FFFFFFF}) begin failures++; $display("FAIL sub_ovf got=%h exp=%h", obs, {4'b1010, 32'h7FFFFFFF}); end
    drain();
    issue(4'b0111, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (obs !== {4'b1000, 32'h1}) begin failures++; $display("FAIL slt_neg got=%h exp=%h", obs, {4'b1000, 32'h1}); end
    drain();
    issue(4'b0111, 32'h80000000, 32'h7FFFFFFF);
    checks++;
    if (obs !== {4'b1000, 32'h1}) begin failures++; $display("FAIL slt_ovf got=%h exp=%h", obs, {4'b1000, 32'h1}); end
    drain();
    issue(4'b0111, 32'h7FFFFFFF, 32'h80000000);
    checks++;
    if (obs !== {4'b1100, 32'h0}) begin failures++; $display("FAIL slt_false got=%h exp=%h", obs, {4'b1100, 32'h0}); end
    drain();
  endtask
  task automatic test_illegal();
    issue(4'b0011, 32'h1234, 32'h5678);
    checks++;
    if (obs !== {4'b1101, 32'h0}) begin failures++; $display("FAIL illegal got=%h exp=%h", obs, {4'b1101, 32'h0}); end
    drain();
    issue(4'b0000, 32'hF0F0, 32'hFF00);
    checks++;
    if (obs !== {4'b1000, 32'hF000}) begin failures++; $display("FAIL and_after_ill got=%h exp=%h", obs, {4'b1000, 32'hF000}); end
    drain();
  endtask
  task automatic test_mul();
`ifdef ALU_EXEC_MUL_EN
    int cnt;
    issue(4'b1000, 32'h00010000, 32'h00010000);
    checks++;
    if ({ready_o, valid_o} !== 2'b00) begin failures++; $display("FAIL mul_busy got=%b exp=00", {ready_o, valid_o}); end
    cnt = 0;
    while (!valid_o && cnt < 100) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (cnt !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", cnt); end
    checks++;
    if (obs !== {4'b1100, 32'h0}) begin failures++; $display("FAIL mul_wrap got=%h exp=%h", obs, {4'b1100, 32'h0}); end
    drain();
    issue(4'b1000, 32'd7, 32'd6);
    cnt = 0;
    while (!valid_o && cnt < 100) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (obs !== {4'b1000, 32'd42}) begin failures++; $display("FAIL mul_7x6 got=%h exp=%h", obs, {4'b1000, 32'd42}); end
    drain();
`else
    issue(4'b1000, 32'h00010000, 32'h00010000);
    checks++;
    if (obs !== {4'b1101, 32'h0}) begin failures++; $display("FAIL mul_illegal got=%h exp=%h", obs, {4'b1101, 32'h0}); end
    drain();
`endif
  endtask
  task automatic test_backpressure();
    ready_i = 1'b0;
    issue(4'b0010, 32'd2, 32'd3);
    valid_i = 1'b1;
    ctrl = 4'b0110;
    src1 = 32'd10;
    src2 = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready_o, obs} !== {1'b0, 4'b1000, 32'd5}) begin failures++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {ready_o, obs}, {1'b0, 4'b1000, 32'd5}); end
    end
    ready_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready got=%b exp=1", ready_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++;
    if (obs !== {4'b1000, 32'd7}) begin failures++; $display("FAIL bp_b2b got=%h exp=%h", obs, {4'b1000, 32'd7}); end
    drain();
  endtask
  task automatic test_back_to_back();
    logic [3:0] c [4] = '{4'b0000, 4'b0001, 4'b1100, 4'b0110};
    logic [31:0] a [4] = '{32'hFFFF, 32'h1, 32'h0, 32'h3};
    logic [31:0] b [4] = '{32'h0F0F, 32'h2, 32'h0, 32'h5};
    logic [31:0] e [4] = '{32'h0F0F, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFE};
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      ctrl = c[i];
      src1 = a[i];
      src2 = b[i];
      @(posedge clk); #1;
      checks++;
      if ({valid_o, result_o} !== {1'b1, e[i]}) begin failures++; $display("FAIL b2b%0d got=%h exp=%h", i, {valid_o, result_o}, {1'b1, e[i]}); end
    end
    valid_i = 1'b0;
    drain();
  endtask
  task automatic test_reset_mid();
`ifdef ALU_EXEC_MUL_EN
    issue(4'b1000, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
`else
    ready_i = 1'b0;
    issue(4'b0010, 32'h7FFFFFFF, 32'h1);
`endif
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ready_o, obs} !== {1'b1, 36'h0}) begin failures++; $display("FAIL reset_mid got=%h exp=%h", {ready_o, obs}, {1'b1, 36'h0}); end
    @(posedge clk); #1;
    rst = 1'b0;
    ready_i = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_discard got=%b exp=0", valid_o); end
    end
    issue(4'b0010, 32'd2, 32'd3);
    checks++;
    if (obs !== {4'b1000, 32'd5}) begin failures++; $display("FAIL add_after_rst got=%h exp=%h", obs, {4'b1000, 32'd5}); end
    drain();
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_illegal();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
# alu_exec

Execution unit on the consumer side of the ALU control interface: accepts a 4-bit ALU control code plus two operands over a valid/ready handshake, computes the result, and presents it with zero/overflow flags over an output valid/ready handshake. Logic ops, add/sub and SLT complete in one cycle. An optional iterative multiplier takes WIDTH cycles. Sits between the ALU control decoder / register-read stage and writeback in the multi-cycle datapath.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request this cycle
- ALUCtrl_i  in  4  operation code
- src1_i  in  WIDTH  operand A
- src2_i  in  WIDTH  operand B
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  WIDTH  result
- zero_o  out  1  result_o == 0
- overflow_o  out  1  signed overflow (ADD/SUB only)
- illegal_o  out  1  unsupported code was issued

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 MUL (only with ALU_EXEC_MUL_EN). All other codes are illegal.
- Request is accepted on a rising edge with valid_i && ready_o. Operands and code are captured on that edge.
- FSM states:
  - IDLE: ready_o=1. Accept → DONE for single-cycle/illegal codes, → MUL for MUL.
  - MUL: ready_o=0, one shift-add step per cycle, WIDTH steps, then → DONE.
  - DONE: valid_o=1 and outputs held stable. On ready_i: if valid_i in the same cycle, accept the new request (ready_o = ready_i, combinational); otherwise → IDLE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH. overflow_o = signed overflow; it is 0 for all other codes.
  - SLT returns 1 if src1 < src2 signed (overflow-corrected sign of the subtraction), else 0.
  - MUL returns the low WIDTH bits of the unsigned product.
- Illegal code: result_o=0, zero_o=1, illegal_o=1, completes like a single-cycle op. illegal_o is registered with the result and held through DONE.
- zero_o is computed from the registered result.

## Timing
- Reset: state IDLE; ready_o=1, valid_o=0, result_o=0, zero_o=0, overflow_o=0, illegal_o=0.
- Single-cycle op accepted at edge N → valid_o high after edge N, i.e. in cycle N+1.
- MUL accepted at edge N → valid_o high after edge N+WIDTH+1.
- With ready_i held high and valid_i back-to-back, throughput is 1 op/cycle for non-MUL codes.
- Backpressure: while valid_o && !ready_i, result and flags do not change and no request is accepted.
- Reset asserted mid-MUL or in DONE: immediate return to reset values; the in-flight op is discarded.
- valid_i while ready_o=0 is ignored. The requester holds the request until it is accepted.

## Configuration
- ALU_EXEC_MUL_EN defined: code 1000 runs the iterative multiply and the MUL state exists.
- ALU_EXEC_MUL_EN undefined: no multiplier logic and no MUL state. Code 1000 is illegal (illegal_o=1, result 0, one cycle).

## Structure
- Shared package alu_pkg holds:
  - localparams for the seven operation codes
  - the FSM state typedef (IDLE, MUL, DONE)
- Natural sub-module: alu_mul_iter. It is a shift-add multiplier with start/done, WIDTH-cycle latency and a low-half product output. It is instantiated only under ALU_EXEC_MUL_EN.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow_o=1, zero_o=0, valid_o one cycle after accept.
- SUB 5 − 5 → result 0, zero_o=1, overflow_o=0. SLT 0xFFFFFFFF vs 0x00000001 → result 1. SLT 0x80000000 vs 0x7FFFFFFF → result 1.
- MUL 0x00010000 × 0x00010000 → result 0, zero_o=1, valid_o at accept+33 cycles. MUL 7 × 6 → 42. Without the macro, the same MUL stimulus → illegal_o=1 after 1 cycle.
- Code 0011 → illegal_o=1, result 0. The following legal AND 0xF0F0 & 0xFF00 → 0xF000, illegal_o=0.
- Hold ready_i=0 for 5 cycles after valid_o → result and flags unchanged, ready_o=0. Release ready_i with a new valid_i → back-to-back accept in the same cycle.
- Assert rst_i 10 cycles into a MUL → all outputs at reset values immediately, state IDLE. The next ADD 2+3 → 5.
